// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: active-low
// glyph patterns, the all-dark pattern and segment bit positions.
package seven_seg_pkg;

   // segment positions inside the 8-bit active-low pattern
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [7:0] SGM_BLANK = 8'hFF;

   localparam logic [7:0] GLYPH_0 = 8'h03;
   localparam logic [7:0] GLYPH_1 = 8'h9F;
   localparam logic [7:0] GLYPH_2 = 8'h25;
   localparam logic [7:0] GLYPH_3 = 8'h0D;
   localparam logic [7:0] GLYPH_4 = 8'h99;
   localparam logic [7:0] GLYPH_5 = 8'h49;
   localparam logic [7:0] GLYPH_6 = 8'h41;
   localparam logic [7:0] GLYPH_7 = 8'h1F;
   localparam logic [7:0] GLYPH_8 = 8'h01;
   localparam logic [7:0] GLYPH_9 = 8'h09;
   localparam logic [7:0] GLYPH_A = 8'h11;
   localparam logic [7:0] GLYPH_B = 8'hC1;
   localparam logic [7:0] GLYPH_C = 8'h63;
   localparam logic [7:0] GLYPH_D = 8'h85;
   localparam logic [7:0] GLYPH_E = 8'h61;
   localparam logic [7:0] GLYPH_F = 8'h71;

   // indexed by nibble value
   localparam logic [15:0][7:0] GLYPH_TAB = {
      GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
      GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
   };

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational nibble + decimal-point to active-low segment pattern.
module seven_seg_glyph
   import seven_seg_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       dp,
   output logic [7:0] sgm
);

   // table lookup, then pull the dp segment low when requested
   always_comb begin
      sgm = GLYPH_TAB[nib];
      if (dp) sgm[SEG_DP] = 1'b0;
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, per-frame
// input snapshot, leading-zero suppression, blink and forced blank.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [4*N_DIGITS-1:0] data,
   input  logic [N_DIGITS-1:0]   dp,
   input  logic [N_DIGITS-1:0]   blank,
   input  logic [N_DIGITS-1:0]   blink,
   input  logic                  lz_en,
   output logic [7:0]            sgm,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_tick
);

   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]                presc;
   logic [IW-1:0]                idx;
   logic [BW-1:0]                bcnt;
   logic                         phase;
   logic                         primed;

   // frame snapshot
   logic [N_DIGITS-1:0][3:0]     s_data;
   logic [N_DIGITS-1:0]          s_dp, s_blank, s_blink;
   logic                         s_lz;

   // frame contents as seen by the output stage; on the very first enabled
   // cycle the snapshot is still empty, so the live inputs stand in for it
   logic [N_DIGITS-1:0][3:0]     v_data;
   logic [N_DIGITS-1:0]          v_dp, v_blank, v_blink;
   logic                         v_lz;

   logic [N_DIGITS-1:0]          supp;
   logic                         run;
   logic [N_DIGITS-1:0][7:0]     glyph, lane;
   logic [7:0]                   sel_sgm;
   logic [N_DIGITS-1:0]          an_nxt;
   logic                         term, wrap;

   assign v_data  = primed ? s_data  : data;
   assign v_dp    = primed ? s_dp    : dp;
   assign v_blank = primed ? s_blank : blank;
   assign v_blink = primed ? s_blink : blink;
   assign v_lz    = primed ? s_lz    : lz_en;

   assign term = (presc == PW'(REFRESH_DIV - 1));
   assign wrap = term && (idx == IW'(N_DIGITS - 1));

   // leading zeros: walk down from the top digit while nibbles stay zero;
   // digit 0 is never suppressed
   always_comb begin
      run  = 1'b1;
      supp = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         run = run & (v_data[k] == 4'h0);
         if (k != 0) supp[k] = v_lz & run;
      end
   end

   // per-digit pattern: blank and blink-off win over everything, a
   // suppressed digit keeps only its dp
   for (genvar g = 0; g < N_DIGITS; g++) begin : g_lane
      seven_seg_glyph u_glyph (
         .nib (v_data[g]),
         .dp  (v_dp[g]),
         .sgm (glyph[g])
      );
      assign lane[g] = (v_blank[g] || (phase && v_blink[g])) ? SGM_BLANK :
                       supp[g] ? {SGM_BLANK[7:1], ~v_dp[g]} : glyph[g];
   end

   // select the pattern and anode for the current index
   always_comb begin
      sel_sgm = SGM_BLANK;
      an_nxt  = '1;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            sel_sgm   = lane[k];
            an_nxt[k] = 1'b0;
         end
      end
   end

   // scan state, snapshot, blink phase and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc      <= '0;
         idx        <= '0;
         bcnt       <= '0;
         phase      <= 1'b0;
         primed     <= 1'b0;
         s_data     <= '0;
         s_dp       <= '0;
         s_blank    <= '0;
         s_blink    <= '0;
         s_lz       <= 1'b0;
         sgm        <= SGM_BLANK;
         an         <= '1;
         frame_tick <= 1'b0;
      end else if (!en) begin
         sgm        <= SGM_BLANK;
         an         <= '1;
         frame_tick <= 1'b0;
      end else begin
         sgm        <= sel_sgm;
         an         <= an_nxt;
         frame_tick <= wrap;
         if (!primed || wrap) begin
            primed  <= 1'b1;
            s_data  <= data;
            s_dp    <= dp;
            s_blank <= blank;
            s_blink <= blink;
            s_lz    <= lz_en;
         end
         if (term) begin
            presc <= '0;
            idx   <= wrap ? '0 : idx + IW'(1);
         end else begin
            presc <= presc + PW'(1);
         end
         if (wrap) begin
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
               bcnt  <= '0;
               phase <= ~phase;
            end else begin
               bcnt <= bcnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with 4 digits, 4-clock dwell, 2-frame blink.
module tb_seven_seg_scan;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BF = 2;
   localparam int FR = ND * RD;

   logic        clk, rst_n, en, lz_en, frame_tick;
   logic [15:0] data;
   logic [3:0]  dp, blank, blink, an;
   logic [7:0]  sgm;

   int checks = 0;
   int failures = 0;
   logic chk_on = 1'b0;

   seven_seg_scan #(.N_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .data(data), .dp(dp),
      .blank(blank), .blink(blink), .lz_en(lz_en),
      .sgm(sgm), .an(an), .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp, blank, blink;
      logic        lz;
   } snap_t;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp, blank, blink;
      logic        lz;
      int          dig;
      logic [7:0]  exp;
   } vec_t;

   logic [7:0] gl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                           8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // expected segments for digit d of a frame snapshot, straight from the rules
   function automatic logic [7:0] ref_sgm(input snap_t s, input int d, input bit ph);
      logic [15:0] upper;
      logic [7:0]  g;
      upper = s.data >> (4 * d);
      if (s.blank[d]) return 8'hFF;
      if (ph && s.blink[d]) return 8'hFF;
      if (s.lz && d != 0 && upper == 16'h0) return s.dp[d] ? 8'hFE : 8'hFF;
      g = gl[upper[3:0]];
      if (s.dp[d]) g[0] = 1'b0;
      return g;
   endfunction

   // reference model: t counts enabled clocks since reset; which digit,
   // which frame and which blink phase follow from plain division
   int    t, md, mf;
   snap_t cur;
   logic [3:0] exp_an;
   logic [7:0] exp_sgm;
   logic       exp_tick;

   always @(posedge clk) begin
      if (!rst_n) begin
         t = 0; exp_an = 4'hF; exp_sgm = 8'hFF; exp_tick = 1'b0;
      end else if (!en) begin
         exp_an = 4'hF; exp_sgm = 8'hFF; exp_tick = 1'b0;
      end else begin
         if (t == 0) cur = '{data, dp, blank, blink, lz_en};
         md = (t / RD) % ND;
         mf = t / FR;
         exp_an = 4'hF;
         exp_an[md] = 1'b0;
         exp_sgm = ref_sgm(cur, md, ((mf / BF) % 2) != 0);
         exp_tick = (t % FR) == FR - 1;
         if (exp_tick) cur = '{data, dp, blank, blink, lz_en};
         t++;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_an", 32'(an), 32'(exp_an));
         chk("model_sgm", 32'(sgm), 32'(exp_sgm));
         chk("model_tick", 32'(frame_tick), 32'(exp_tick));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // two reset clocks, then release with the given inputs and en=1
   task automatic do_reset(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                           input logic [3:0] k, input logic l);
      rst_n = 1'b0; en = 1'b0;
      step(2);
      data = d; dp = p; blank = b; blink = k; lz_en = l;
      rst_n = 1'b1; en = 1'b1;
   endtask

   vec_t vt [18];

   initial begin
      vt[0]  = '{16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 0, 8'h99};
      vt[1]  = '{16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1, 8'h0D};
      vt[2]  = '{16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 2, 8'h25};
      vt[3]  = '{16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 3, 8'h9F};
      vt[4]  = '{16'h0070, 4'h8, 4'h0, 4'h0, 1'b1, 3, 8'hFE};
      vt[5]  = '{16'h0070, 4'h8, 4'h0, 4'h0, 1'b1, 2, 8'hFF};
      vt[6]  = '{16'h0070, 4'h8, 4'h0, 4'h0, 1'b1, 1, 8'h1F};
      vt[7]  = '{16'h0070, 4'h8, 4'h0, 4'h0, 1'b1, 0, 8'h03};
      vt[8]  = '{16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0, 0, 8'h85};
      vt[9]  = '{16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0, 3, 8'h11};
      vt[10] = '{16'hEF56, 4'h0, 4'h0, 4'h0, 1'b0, 2, 8'h71};
      vt[11] = '{16'hEF56, 4'h0, 4'h0, 4'h0, 1'b0, 1, 8'h49};
      vt[12] = '{16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 0, 8'h03};
      vt[13] = '{16'h0100, 4'h0, 4'h0, 4'h0, 1'b1, 1, 8'h03};
      vt[14] = '{16'h1234, 4'h2, 4'h2, 4'h0, 1'b0, 1, 8'hFF};
      vt[15] = '{16'h0008, 4'h1, 4'h0, 4'h0, 1'b0, 0, 8'h00};
      vt[16] = '{16'h0008, 4'h0, 4'h0, 4'h1, 1'b0, 0, 8'h01};
      vt[17] = '{16'h00C0, 4'h0, 4'h0, 4'h0, 1'b1, 3, 8'hFF};

      rst_n = 1'b0; en = 1'b0; data = '0; dp = '0; blank = '0; blink = '0; lz_en = 1'b0;
      step(2);
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_sgm", 32'(sgm), 32'hFF);
      chk("reset_tick", 32'(frame_tick), 32'h0);
      chk_on = 1'b1;

      // table: digit dig of the first frame is lit RD*dig clocks after start
      for (int i = 0; i < 18; i++) begin
         logic [3:0] ea;
         do_reset(vt[i].data, vt[i].dp, vt[i].blank, vt[i].blink, vt[i].lz);
         step(1 + vt[i].dig * RD);
         ea = 4'hF;
         ea[vt[i].dig] = 1'b0;
         chk($sformatf("vec%0d_sgm", i), 32'(sgm), 32'(vt[i].exp));
         chk($sformatf("vec%0d_an", i), 32'(an), 32'(ea));
      end

      // mid-frame data change only shows from the next frame
      do_reset(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1);
      chk("seq_first_an", 32'(an), 32'hE);
      chk("seq_first_sgm", 32'(sgm), 32'h99);
      step(6);
      data = 16'hABCD;
      step(9);
      chk("seq_old_frame_sgm", 32'(sgm), 32'h9F);
      chk("seq_tick", 32'(frame_tick), 32'h1);
      step(1);
      chk("seq_new_frame_sgm", 32'(sgm), 32'h85);
      chk("seq_tick_one_cycle", 32'(frame_tick), 32'h0);

      // enable pause inside digit 1 keeps the remaining dwell
      do_reset(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
      step(6);
      en = 1'b0;
      step(1);
      chk("pause_an", 32'(an), 32'hF);
      chk("pause_sgm", 32'(sgm), 32'hFF);
      step(9);
      en = 1'b1;
      step(1);
      chk("resume_an0", 32'(an), 32'hD);
      chk("resume_sgm0", 32'(sgm), 32'h0D);
      step(1);
      chk("resume_an1", 32'(an), 32'hD);
      step(1);
      chk("resume_an2", 32'(an), 32'hB);

      // reset during digit 2, restart from digit 0 with fresh data
      do_reset(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
      step(10);
      chk("pre_reset_an", 32'(an), 32'hB);
      rst_n = 1'b0;
      step(1);
      chk("midrst_an", 32'(an), 32'hF);
      chk("midrst_sgm", 32'(sgm), 32'hFF);
      chk("midrst_tick", 32'(frame_tick), 32'h0);
      data = 16'h5678;
      rst_n = 1'b1;
      step(1);
      chk("after_rst_an", 32'(an), 32'hE);
      chk("after_rst_sgm", 32'(sgm), 32'h01);

      // blink: two frames lit, two dark, lit again
      do_reset(16'h0008, 4'h0, 4'h0, 4'h1, 1'b0);
      step(1);
      for (int f = 0; f < 5; f++) begin
         chk($sformatf("blink_f%0d", f), 32'(sgm), ((f / 2) % 2 != 0) ? 32'hFF : 32'h01);
         if (f == 2) begin
            step(4);
            chk("blink_other_digit", 32'(sgm), 32'h03);
            step(12);
         end else begin
            step(16);
         end
      end

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) data = 16'($urandom);
         if ($urandom_range(15) == 0) dp = 4'($urandom);
         if ($urandom_range(15) == 0) blank = 4'($urandom) & 4'($urandom) & 4'($urandom);
         if ($urandom_range(15) == 0) blink = 4'($urandom);
         if ($urandom_range(15) == 0) lz_en = 1'($urandom);
         if ($urandom_range(31) == 0 && data[15:8] != 8'h0) data[15:8] = 8'h0;
         en = ($urandom_range(12) != 0);
         rst_n = ($urandom_range(499) != 0);
         step(1);
      end
      rst_n = 1'b1; en = 1'b1;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
